// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: opcodes, function codes and the loader's op_kind encoding.
// The control decoder and the program loader both import this so they cannot drift apart.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2a;

    localparam logic [2:0] KIND_RTYPE = 3'd0;
    localparam logic [2:0] KIND_ADDI  = 3'd1;
    localparam logic [2:0] KIND_LW    = 3'd2;
    localparam logic [2:0] KIND_SW    = 3'd3;
    localparam logic [2:0] KIND_BEQ   = 3'd4;

endpackage

// File: rtl/instr_word_encode.sv
// Combinational packer: symbolic instruction (kind plus fields) to a 32-bit MIPS word.
// Kinds outside RTYPE..BEQ produce a zero word with legal deasserted.
module instr_word_encode
    import mips_isa_pkg::*;
(
    input  logic [2:0]  op_kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    output logic [31:0] instr_word,
    output logic        legal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch behind.
        instr_word = '0;
        legal      = 1'b1;
        unique case (op_kind)
            KIND_RTYPE: instr_word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
            KIND_ADDI:  instr_word = {OP_ADDI,  rs, rt, imm};
            KIND_LW:    instr_word = {OP_LW,    rs, rt, imm};
            KIND_SW:    instr_word = {OP_SW,    rs, rt, imm};
            KIND_BEQ:   instr_word = {OP_BEQ,   rs, rt, imm};
            default:    legal      = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: accepts symbolic instructions over valid/ready, encodes them and
// writes them to consecutive instruction-memory words through a one-cycle write stage.
module instr_encode_loader
    import mips_isa_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         finish,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   op_kind,
    input  logic [4:0]                   rs,
    input  logic [4:0]                   rt,
    input  logic [4:0]                   rd,
    input  logic [5:0]                   funct,
    input  logic [15:0]                  imm,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   word_count,
    output logic                         busy,
    output logic                         full,
    output logic                         done,
    output logic                         err_illegal
);

    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FULL,
        ST_DONE
    } load_state_e;

    load_state_e state, state_next;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              accept;
    logic              write_now;
    logic [ADDR_W-1:0] write_addr;

    instr_word_encode u_encode (
        .op_kind    (op_kind),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .funct      (funct),
        .imm        (imm),
        .instr_word (enc_word),
        .legal      (enc_legal)
    );

    // start and finish both close the handshake so neither races an accept.
    assign in_ready   = (state == ST_LOAD) && !start && !finish && (word_count < CW'(DEPTH));
    assign accept     = in_valid && in_ready;
    assign write_now  = accept && enc_legal;
    assign write_addr = ADDR_W'(BASE_ADDR) + (ADDR_W'(word_count) << 2);

    assign busy = (state == ST_LOAD);
    assign full = (state == ST_FULL);
    assign done = (state == ST_DONE);

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start) state_next = ST_LOAD;
            ST_LOAD: begin
                if (start)
                    state_next = ST_LOAD;
                else if (finish)
                    state_next = ST_DONE;
                else if (write_now && word_count == CW'(DEPTH - 1))
                    state_next = ST_FULL;
            end
            ST_FULL: begin
                if (start)
                    state_next = ST_LOAD;
                else if (finish)
                    state_next = ST_DONE;
            end
            ST_DONE: if (start) state_next = ST_LOAD;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mem_we      <= 1'b0;
            mem_addr    <= ADDR_W'(BASE_ADDR);
            mem_wdata   <= '0;
            word_count  <= '0;
            err_illegal <= 1'b0;
        end else begin
            state  <= state_next;
            mem_we <= write_now;
            if (write_now) begin
                mem_addr  <= write_addr;
                mem_wdata <= enc_word;
            end
            if (start) begin
                word_count  <= '0;
                err_illegal <= 1'b0;
            end else if (accept) begin
                if (enc_legal)
                    word_count <= word_count + CW'(1);
                else
                    err_illegal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader (DEPTH=4): expected writes are queued when
// an instruction is accepted and compared by a monitor when mem_we appears.
module tb_instr_encode_loader;
    import mips_isa_pkg::*;

    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 8;
    localparam int BASE_ADDR = 0;
    localparam int CW        = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, finish, in_valid, in_ready;
    logic [2:0]        op_kind;
    logic [4:0]        rs, rt, rd;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [CW-1:0]     word_count;
    logic              busy, full, done, err_illegal;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  exp_count = 0;
    int  passed    = 0;
    int  total     = 0;

    instr_encode_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .op_kind(op_kind),
        .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .word_count(word_count), .busy(busy), .full(full), .done(done),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // Write monitor: every observed write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write addr=%h data=%h (no write expected)", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data)
                    $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                             mem_addr, mem_wdata, e.addr, e.data);
                else
                    passed++;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        exp_count = 0;
    endtask

    task automatic pulse_finish();
        @(negedge clk);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
    endtask

    // Drives one instruction; the expected write is queued only if the bench sees the handshake.
    task automatic send(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [5:0] f, input logic [15:0] im,
                        input logic [31:0] w, input bit legal);
        @(negedge clk);
        op_kind = k; rs = s; rt = t; rd = d; funct = f; imm = im;
        in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL send_ready in_ready=%b expected 1 (kind %0d)", in_ready, k);
        end else begin
            passed++;
            if (legal) begin
                exp_q.push_back('{addr: ADDR_W'(BASE_ADDR + 4*exp_count), data: w});
                exp_count++;
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b1;
        op_kind = '0; rs = '0; rt = '0; rd = '0; funct = '0; imm = '0;
        repeat (2) @(negedge clk);
        #1;
        total += 7;
        if ({in_ready, mem_we, busy, full, done, err_illegal} !== 6'b0)
            $display("FAIL reset_flags got %b expected 000000", {in_ready, mem_we, busy, full, done, err_illegal});
        else passed++;
        if (mem_addr !== ADDR_W'(BASE_ADDR)) $display("FAIL reset_addr got %h expected %h", mem_addr, BASE_ADDR);
        else passed++;
        if (mem_wdata !== 32'h0) $display("FAIL reset_wdata got %h expected 0", mem_wdata);
        else passed++;
        if (word_count !== '0) $display("FAIL reset_count got %0d expected 0", word_count);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        if (in_ready !== 1'b0) $display("FAIL idle_ready got %b expected 0", in_ready);
        else passed++;
        if (busy !== 1'b0) $display("FAIL idle_busy got %b expected 0", busy);
        else passed++;
        if (mem_we !== 1'b0) $display("FAIL idle_we got %b expected 0", mem_we);
        else passed++;
        in_valid = 1'b0;
    endtask

    task automatic test_rtype();
        pulse_start();
        #1;
        total++;
        if (busy !== 1'b1) $display("FAIL start_busy got %b expected 1", busy);
        else passed++;
        send(KIND_RTYPE, 5'd1, 5'd2, 5'd3, FUNCT_ADD, 16'h0, 32'h00221820, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total += 2;
        if (mem_we !== 1'b1) $display("FAIL rtype_we got %b expected 1", mem_we);
        else passed++;
        if (word_count !== CW'(1)) $display("FAIL rtype_count got %0d expected 1", word_count);
        else passed++;
    endtask

    task automatic test_back_to_back();
        pulse_start();
        send(KIND_ADDI, 5'd0,  5'd5, 5'd9, 6'h3f, 16'h0007, 32'h20050007, 1'b1);
        send(KIND_LW,   5'd29, 5'd8, 5'd0, 6'h00, 16'h0004, 32'h8FA80004, 1'b1);
        send(KIND_SW,   5'd29, 5'd8, 5'd0, 6'h00, 16'h0008, 32'hAFA80008, 1'b1);
        send(KIND_BEQ,  5'd1,  5'd2, 5'd0, 6'h00, 16'hFFFF, 32'h1022FFFF, 1'b1);
        // Keep valid high with a fifth instruction; it must never be taken.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++;
            if (in_ready !== 1'b0 || full !== 1'b1 || word_count !== CW'(DEPTH))
                $display("FAIL full_hold cycle %0d ready=%b full=%b count=%0d expected ready=0 full=1 count=%0d",
                         i, in_ready, full, word_count, DEPTH);
            else passed++;
        end
        in_valid = 1'b0;
        pulse_finish();
        #1;
        total++;
        if (done !== 1'b1 || full !== 1'b0) $display("FAIL finish_done done=%b full=%b expected done=1 full=0", done, full);
        else passed++;
    endtask

    task automatic test_illegal();
        pulse_start();
        send(3'd6, 5'd1, 5'd2, 5'd3, 6'h20, 16'h1234, 32'h0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total += 3;
        if (err_illegal !== 1'b1) $display("FAIL illegal_err got %b expected 1", err_illegal);
        else passed++;
        if (word_count !== '0) $display("FAIL illegal_count got %0d expected 0", word_count);
        else passed++;
        if (mem_we !== 1'b0) $display("FAIL illegal_we got %b expected 0", mem_we);
        else passed++;
        send(KIND_ADDI, 5'd3, 5'd4, 5'd0, 6'h00, 16'h8000, 32'h20648000, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (err_illegal !== 1'b1) $display("FAIL illegal_sticky got %b expected 1", err_illegal);
        else passed++;
        pulse_start();
        #1;
        total++;
        if (err_illegal !== 1'b0 || word_count !== '0)
            $display("FAIL start_clear err=%b count=%0d expected err=0 count=0", err_illegal, word_count);
        else passed++;
    endtask

    task automatic test_start_priority();
        send(KIND_LW, 5'd7, 5'd6, 5'd0, 6'h00, 16'h0010, 32'h8CE60010, 1'b1);
        @(negedge clk);
        start = 1'b1;
        op_kind = KIND_SW; rs = 5'd1; rt = 5'd1; imm = 16'h0;
        in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL start_blocks_ready got %b expected 0", in_ready);
        else passed++;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        exp_count = 0;
        #1;
        total++;
        if (word_count !== '0 || busy !== 1'b1)
            $display("FAIL start_prio_count count=%0d busy=%b expected count=0 busy=1", word_count, busy);
        else passed++;
        send(KIND_RTYPE, 5'd4, 5'd5, 5'd6, FUNCT_SLT, 16'h0, 32'h0085302A, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_finish_after_last();
        send(KIND_SW, 5'd2, 5'd3, 5'd0, 6'h00, 16'h000C, 32'hAC43000C, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        finish   = 1'b1;
        #1;
        total++;
        if (mem_we !== 1'b1) $display("FAIL finish_pending_we got %b expected 1", mem_we);
        else passed++;
        @(negedge clk);
        finish = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || word_count !== CW'(2))
            $display("FAIL finish_last done=%b count=%0d expected done=1 count=2", done, word_count);
        else passed++;
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send(KIND_BEQ, 5'd9, 5'd10, 5'd0, 6'h00, 16'h0003, 32'h112A0003, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_we !== 1'b0) $display("FAIL reset_mid_we got %b expected 0", mem_we);
        else passed++;
        // The dropped write must never reach the bus.
        void'(exp_q.pop_back());
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total += 2;
        if ({in_ready, mem_we, busy, full, done, err_illegal} !== 6'b0 || word_count !== '0)
            $display("FAIL reset_mid_state flags=%b count=%0d expected 000000 count=0",
                     {in_ready, mem_we, busy, full, done, err_illegal}, word_count);
        else passed++;
        if (mem_addr !== ADDR_W'(BASE_ADDR) || mem_wdata !== 32'h0)
            $display("FAIL reset_mid_bus addr=%h data=%h expected %h 0", mem_addr, mem_wdata, BASE_ADDR);
        else passed++;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_back_to_back();
        test_illegal();
        test_start_priority();
        test_finish_after_last();
        test_reset_mid();
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) $display("FAIL drain outstanding=%0d expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout bench did not finish within 20000 time units");
        $fatal(1);
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Encoder counterpart to the control-unit opcode decoder: accepts symbolic instructions (kind plus fields) over a valid/ready handshake.
- Packs each instruction into a 32-bit MIPS word and writes the words sequentially into instruction memory.
- Sits between the bench/boot host and the instruction memory write port; used to load programs for the single-cycle datapath.

Parameters:
- DEPTH, 64, number of instruction words the memory holds.
- ADDR_W, 8, byte-address width of mem_addr; must satisfy 4*DEPTH <= 2**ADDR_W.
- BASE_ADDR, 0, byte address of the first loaded word; must be word-aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; clears count/error and enters LOAD.
- finish  in  1  one-cycle pulse; ends loading (LOAD or FULL -> DONE).
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  loader can accept an instruction this cycle.
- op_kind  in  3  0 RTYPE, 1 ADDI, 2 LW, 3 SW, 4 BEQ; 5-7 illegal.
- rs, rt, rd  in  5 each  register fields.
- funct  in  6  R-type function field.
- imm  in  16  immediate / offset (BEQ: word offset, passed through unchanged).
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  byte address of the write.
- mem_wdata  out  32  encoded instruction word.
- word_count  out  $clog2(DEPTH+1)  words written since start.
- busy  out  1  state is LOAD.
- full  out  1  state is FULL.
- done  out  1  state is DONE.
- err_illegal  out  1  sticky; set when an illegal op_kind is accepted.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready, mem_we, busy, full, done and err_illegal are 0; mem_addr=BASE_ADDR; mem_wdata=0; word_count=0.
- States: IDLE, LOAD, FULL, DONE.
  - IDLE -start-> LOAD.
  - LOAD -finish-> DONE.
  - LOAD -(word_count reaches DEPTH)-> FULL.
  - FULL -finish-> DONE.
  - DONE -start-> LOAD.
  - start in LOAD, FULL or DONE -> LOAD with word_count=0 and err_illegal=0.
- start has priority over finish and over an accept in the same cycle.
- in_ready = (state==LOAD) && !start && !finish && (word_count<DEPTH). The output is combinational from registered state and the start/finish inputs.
- Accept = in_valid && in_ready.
- Accepted legal word: exactly one cycle after the accept, mem_we=1 for one cycle.
  - mem_addr = BASE_ADDR + 4*word_count (the pre-increment value).
  - mem_wdata = the encoded word.
  - word_count increments on that same edge.
- Back-to-back accepts produce back-to-back writes; throughput is 1 word/cycle.
- Encodings:
  - RTYPE = {6'b000000, rs, rt, rd, 5'b00000, funct}.
  - ADDI = {6'b001000, rs, rt, imm}.
  - LW = {6'b100011, rs, rt, imm}.
  - SW = {6'b101011, rs, rt, imm}.
  - BEQ = {6'b000100, rs, rt, imm}.
  - rd and funct are ignored for I-type kinds.
- Illegal op_kind: the handshake completes, no write occurs, word_count is unchanged, err_illegal is set and held until start or reset.
- Full boundary: the accept that makes word_count==DEPTH moves the block to FULL on the next edge; in_ready is 0 from that edge onward. No address wrap-around ever occurs.
- finish in the cycle after the last accept: the pending write still completes; the state becomes DONE on the same edge.
- Reset mid-load: all state is cleared immediately, any pending write is dropped, and mem_we drops asynchronously.

Decomposition:
- Shared package mips_isa_pkg:
  - Opcode localparams OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ (the same values the control decoder uses).
  - op_kind encodings KIND_*.
  - FUNCT_ADD/SUB/AND/OR/SLT constants.
- Sub-module instr_word_encode: purely combinational (op_kind plus fields -> 32-bit word and a legal flag).
- The top level holds the FSM, counter, and the registered write stage.

Test Plan:
- Reset, then start; RTYPE rs=1 rt=2 rd=3 funct=0x20 -> next cycle mem_we=1, addr=0x00, wdata=0x00221820, word_count=1.
- Back-to-back with valid held high: ADDI rs=0 rt=5 imm=0x0007, LW rs=29 rt=8 imm=4, SW rs=29 rt=8 imm=8, BEQ rs=1 rt=2 imm=0xFFFF.
  - Expect writes 0x20050007, 0x8FA80004, 0xAFA80008, 0x1022FFFF at consecutive addresses 0x00, 0x04, 0x08, 0x0C.
- op_kind=6 with valid -> handshake completes, no mem_we, err_illegal=1, word_count unchanged; next start clears err_illegal.
- DEPTH=4: after 4 accepts -> full=1, in_ready=0, a 5th valid is never accepted; finish -> done=1.
- start and in_valid in the same cycle while in LOAD -> no accept, word_count=0, the next accepted word is written to BASE_ADDR.
- rst_n asserted the cycle after an accept -> mem_we drops immediately; after release the outputs match reset values and state is IDLE.
